// File: rtl/alu_exec_unit_if.sv
// Operation request / result bundle between an issuing stage and alu_exec_unit.
// overflow exists only when ALU_OVERFLOW_EN is defined.
// master drives requests and acknowledges results; slave is the execute unit.
interface alu_exec_unit_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);
    logic                   op_valid;
    logic                   op_ready;
    logic [3:0]             alu_operation;
    logic [DATA_WIDTH-1:0]  operand_a;
    logic [DATA_WIDTH-1:0]  operand_b;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   result_valid;
    logic                   result_ready;
    logic [DATA_WIDTH-1:0]  result;
    logic                   zero;
    logic                   illegal_op;
`ifdef ALU_OVERFLOW_EN
    logic                   overflow;
`endif

    modport master (
        output op_valid, alu_operation, operand_a, operand_b, shamt, result_ready,
`ifdef ALU_OVERFLOW_EN
        input  overflow,
`endif
        input  op_ready, result_valid, result, zero, illegal_op
    );

    modport slave (
        input  op_valid, alu_operation, operand_a, operand_b, shamt, result_ready,
`ifdef ALU_OVERFLOW_EN
        output overflow,
`endif
        output op_ready, result_valid, result, zero, illegal_op
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Iterative execute ALU (AND/OR/NOR/ADD/SUB/SRL/SLL); ALU_OVERFLOW_EN adds signed-overflow flag.
// Latency: logic/arith 1 cycle accept->result_valid; shifts shamt+1 cycles (one bit per cycle).
// Backpressure: result held in DONE until result_ready; op_ready only in IDLE, one idle cycle between ops.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_unit_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;

    localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             state;
    logic [3:0]             op_q;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0]  res_q;
    logic                   zero_q;
    logic                   ill_q;

    logic [DATA_WIDTH-1:0]  sum;
    logic [DATA_WIDTH-1:0]  diff;
    logic [DATA_WIDTH-1:0]  exec_res;
    logic                   exec_ill;
    logic                   accept;
    logic                   is_shift;
    logic [DATA_WIDTH-1:0]  shift_nxt;

`ifdef ALU_OVERFLOW_EN
    logic                   ovf_q;
    logic                   exec_ovf;
`endif

    assign accept   = bus.op_valid && (state == ST_IDLE);
    assign is_shift = (bus.alu_operation == OP_SRL) || (bus.alu_operation == OP_SLL);

    // b_q doubles as the shift working register once the op is latched.
    assign shift_nxt = (op_q == OP_SRL) ? {1'b0, b_q[DATA_WIDTH-1:1]}
                                        : {b_q[DATA_WIDTH-2:0], 1'b0};

    always_comb begin
        sum      = a_q + b_q;
        diff     = a_q - b_q;
        exec_res = '0;
        exec_ill = 1'b0;
        case (op_q)
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_NOR:  exec_res = ~(a_q | b_q);
            OP_ADD:  exec_res = sum;
            OP_SUB:  exec_res = diff;
            default: exec_ill = 1'b1;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        exec_ovf = 1'b0;
        if (op_q == OP_ADD) begin
            exec_ovf = (a_q[DATA_WIDTH-1] == b_q[DATA_WIDTH-1]) &&
                       (sum[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
        end else if (op_q == OP_SUB) begin
            exec_ovf = (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &&
                       (diff[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            zero_q <= 1'b1;
            ill_q  <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= bus.alu_operation;
                        a_q   <= bus.operand_a;
                        b_q   <= bus.operand_b;
                        cnt_q <= bus.shamt;
                        state <= is_shift ? ST_SHIFT : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_q  <= exec_res;
                    zero_q <= (exec_res == '0);
                    ill_q  <= exec_ill;
`ifdef ALU_OVERFLOW_EN
                    ovf_q  <= exec_ovf;
`endif
                    state  <= ST_DONE;
                end
                ST_SHIFT: begin
                    if (cnt_q == '0) begin
                        res_q  <= b_q;
                        zero_q <= (b_q == '0);
                        ill_q  <= 1'b0;
`ifdef ALU_OVERFLOW_EN
                        ovf_q  <= 1'b0;
`endif
                        state  <= ST_DONE;
                    end else begin
                        b_q   <= shift_nxt;
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (bus.result_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.op_ready     = (state == ST_IDLE);
    assign bus.result_valid = (state == ST_DONE);
    assign bus.result       = res_q;
    assign bus.zero         = zero_q;
    assign bus.illegal_op   = ill_q;
`ifdef ALU_OVERFLOW_EN
    assign bus.overflow     = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed corner ops, backpressure, reset abort, then random ops
// checked against an arithmetic reference model.
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus ();

    alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: plain integer arithmetic, full-width shifts, signed range test for overflow.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh);
        exp_t   e;
        longint sa, sbv, s;
        e   = '0;
        sa  = $signed(a);
        sbv = $signed(b);
        s   = 0;
        case (op)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd2: e.res = ~(a | b);
            4'd3: begin e.res = a + b; s = sa + sbv; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd4: begin e.res = a - b; s = sa - sbv; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd5: e.res = b >> sh;
            4'd6: e.res = b << sh;
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Monitor: every presented result must match the head of the scoreboard; pop on handshake.
    always @(negedge clk) begin
        if (!reset && bus.result_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got 0x%08h with empty scoreboard at %0t", bus.result, $time);
            end else begin
                exp_t e;
                e = exp_q[0];
                check("result", bus.result, e.res);
                check("zero", {31'd0, bus.zero}, {31'd0, e.z});
                check("illegal_op", {31'd0, bus.illegal_op}, {31'd0, e.ill});
`ifdef ALU_OVERFLOW_EN
                check("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
`endif
                if (bus.result_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic scramble_inputs();
        bus.alu_operation = 4'($urandom);
        bus.operand_a     = $urandom;
        bus.operand_b     = $urandom;
        bus.shamt         = 5'($urandom);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input int stall);
        int n;
        int lat;
        int want_lat;
        n = 0;
        while (!bus.op_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("op_ready_idle", {31'd0, bus.op_ready}, 32'd1);
        exp_q.push_back(model(op, a, b, sh));
        bus.op_valid      = 1'b1;
        bus.alu_operation = op;
        bus.operand_a     = a;
        bus.operand_b     = b;
        bus.shamt         = sh;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        scramble_inputs();
        check("op_ready_busy", {31'd0, bus.op_ready}, 32'd0);
        want_lat = (op == 4'd5 || op == 4'd6) ? int'(sh) + 1 : 1;
        lat = 0;
        while (!bus.result_valid && lat < 64) begin
            bus.result_ready = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        bus.result_ready = 1'b0;
        check("latency", lat, want_lat);
        for (int i = 0; i < stall; i++) begin
            bus.op_valid = 1'b1;
            scramble_inputs();
            @(posedge clk); #1;
        end
        bus.op_valid = 1'b0;
        check("op_ready_done", {31'd0, bus.op_ready}, 32'd0);
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        check("result_valid_after_ack", {31'd0, bus.result_valid}, 32'd0);
        check("op_ready_after_ack", {31'd0, bus.op_ready}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        saw;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        reset             = 1'b1;
        bus.op_valid      = 1'b0;
        bus.result_ready  = 1'b0;
        bus.alu_operation = 4'd0;
        bus.operand_a     = 32'd0;
        bus.operand_b     = 32'd0;
        bus.shamt         = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_op_ready", {31'd0, bus.op_ready}, 32'd1);
        check("rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", {31'd0, bus.zero}, 32'd1);
        check("rst_illegal", {31'd0, bus.illegal_op}, 32'd0);
`ifdef ALU_OVERFLOW_EN
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(4'b0011, 32'h5, 32'h3, 5'd0, 0);
        do_op(4'b0100, 32'h7, 32'h7, 5'd0, 0);
        do_op(4'b0010, 32'h0, 32'h0, 5'd0, 0);
        do_op(4'b1001, 32'h1234, 32'h5678, 5'd0, 0);
        do_op(4'b0000, 32'hF0F0_FFFF, 32'h0FF0_00FF, 5'd0, 0);
        do_op(4'b0110, 32'h0000_0000, 32'h0000_0001, 5'd31, 0);
        do_op(4'b0101, 32'h0, 32'h8000_0000, 5'd0, 0);
        do_op(4'b0101, 32'h0, 32'h8000_0000, 5'd31, 0);
        do_op(4'b0011, 32'h7FFF_FFFF, 32'h1, 5'd0, 0);
        do_op(4'b0100, 32'h8000_0000, 32'h1, 5'd0, 0);
        do_op(4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, 5'd0, 5);

        // Reset during a long shift must abort it without ever presenting a result.
        bus.op_valid      = 1'b1;
        bus.alu_operation = 4'b0110;
        bus.operand_b     = 32'h1;
        bus.shamt         = 5'd20;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_op_ready", {31'd0, bus.op_ready}, 32'd1);
        check("abort_result", bus.result, 32'd0);
        check("abort_zero", {31'd0, bus.zero}, 32'd1);
        saw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            saw = saw | bus.result_valid;
        end
        check("abort_no_result", {31'd0, saw}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            case ($urandom_range(0, 5))
                0:       ra = 32'h7FFF_FFFF;
                1:       ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = ra;
                1:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb, 5'($urandom), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
